// File: rtl/ahb_modport_pkg.sv
// ahb_modport_pkg
// Shared types for the ahb_modport AHB slave endpoint. It holds the AHB
// transfer/size/burst/response encodings, the OKAY/ERROR response constants
// and the slave response state encoding.
package ahb_modport_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_t;

  localparam hresp_t OKAY  = HRESP_OKAY;
  localparam hresp_t ERROR = HRESP_ERROR;

  // ST_WAIT is only reachable when read wait states are compiled in.
  typedef enum logic [1:0] {
    ST_IDLE_OK = 2'd0,
    ST_ERR1    = 2'd1,
    ST_ERR2    = 2'd2,
    ST_WAIT    = 2'd3
  } state_t;

  // NONSEQ and SEQ are the only transfer types that carry an access.
  function automatic logic trans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_modport_if.sv
// ahb_modport_if
// AHB-Lite bus bundle between a master and the ahb_modport slave.
//   master modport: drives htrans/hburst/hsize/hwrite/haddr/hwdata,
//                   receives hrdata/hready/hresp
//   slave  modport: the mirror image
interface ahb_modport_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [1:0]            htrans;
  logic [2:0]            hburst;
  logic [2:0]            hsize;
  logic                  hwrite;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic [1:0]            hresp;

  modport master (
    output htrans, hburst, hsize, hwrite, haddr, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  htrans, hburst, hsize, hwrite, haddr, hwdata,
    output hrdata, hready, hresp
  );

endinterface

// File: rtl/ahb_modport_mem.sv
// ahb_modport_mem
// MEM_DEPTH x DATA_WIDTH flop array backing the AHB slave.
//   clk   : write clock
//   rst   : asynchronous active-high clear of every word
//   we    : commit the byte lanes selected by be at the next rising edge
//   be    : per-byte write enables, bit i covers wdata[8*i +: 8]
//   idx   : word index used for both the write and the combinational read
//   wdata : write data
//   rdata : stored word at idx (combinational)
module ahb_modport_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [DATA_WIDTH/8-1:0]      be,
  input  logic [$clog2(MEM_DEPTH)-1:0] idx,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) mem_d[idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/ahb_modport.sv
// ahb_modport
// AHB-Lite slave endpoint: word-addressed memory with byte-lane writes,
// zero-wait OKAY responses and a two-cycle ERROR response for oversized,
// misaligned or out-of-range transfers.
//   hclk    : bus clock, all state changes on the rising edge
//   hresetn : asynchronous active-high reset (name kept from the bus codebase)
//   bus     : ahb_modport_if slave modport (htrans/hburst/hsize/hwrite/haddr/
//             hwdata in, hrdata/hready/hresp out)
// Build option: define AHB_WAIT_STATE_EN to insert one wait state in front of
// every non-error read data phase; writes stay zero-wait either way.
module ahb_modport
  import ahb_modport_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64
) (
  input  logic         hclk,
  input  logic         hresetn,
  ahb_modport_if.slave bus
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LANE_W    = $clog2(BYTES);
  localparam int IDX_W     = $clog2(MEM_DEPTH);
  localparam int DPH_AW    = LANE_W + IDX_W;
  localparam int MEM_BYTES = MEM_DEPTH * BYTES;

  // Oversized, misaligned or beyond-the-array transfers get the ERROR response.
  function automatic logic xfer_err(input logic [ADDR_WIDTH-1:0] addr,
                                    input logic [2:0]            size);
    logic [ADDR_WIDTH-1:0] align_mask;
    align_mask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
    return (int'(size) > LANE_W) ||
           ((addr & align_mask) != '0) ||
           (addr >= ADDR_WIDTH'(MEM_BYTES));
  endfunction

  // Byte lanes covered by an aligned transfer of 2**size bytes at lane off.
  function automatic logic [BYTES-1:0] lane_en(input logic [LANE_W-1:0] off,
                                               input logic [2:0]        size);
    logic [BYTES-1:0] en;
    int first;
    int last;
    first = int'(off);
    last  = first + (1 << size);
    for (int i = 0; i < BYTES; i++) en[i] = (i >= first) && (i < last);
    return en;
  endfunction

  state_t              state_q, state_d;
  logic                dph_valid_q, dph_valid_d;
  logic                dph_write_q, dph_write_d;
  logic [DPH_AW-1:0]   dph_addr_q, dph_addr_d;
  logic [2:0]          dph_size_q, dph_size_d;

  logic                hready_int;
  logic                accept;
  logic                acc_err;
  logic                mem_we;
  logic [BYTES-1:0]    mem_be;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                unused_hburst;

  // hburst is carried on the bus for monitors only; it never alters a response.
  assign unused_hburst = ^bus.hburst;

  // Address phase: sampled on any edge where the previous data phase completes.
  always_comb begin
    hready_int = (state_q == ST_IDLE_OK) || (state_q == ST_ERR2);
    accept     = hready_int && trans_active(bus.htrans);
    acc_err    = accept && xfer_err(bus.haddr, bus.hsize);
  end

  always_comb begin
    state_d     = state_q;
    dph_valid_d = dph_valid_q;
    dph_write_d = dph_write_q;
    dph_addr_d  = dph_addr_q;
    dph_size_d  = dph_size_q;
    case (state_q)
      ST_IDLE_OK, ST_ERR2: begin
        // Flagged transfers never open a data phase, so they cannot write.
        dph_valid_d = accept && !acc_err;
        if (accept) begin
          dph_write_d = bus.hwrite;
          dph_addr_d  = bus.haddr[DPH_AW-1:0];
          dph_size_d  = bus.hsize;
        end
        if (acc_err) state_d = ST_ERR1;
`ifdef AHB_WAIT_STATE_EN
        else if (accept && !bus.hwrite) state_d = ST_WAIT;
`endif
        else state_d = ST_IDLE_OK;
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_WAIT: state_d = ST_IDLE_OK;
      default: state_d = ST_IDLE_OK;
    endcase
  end

  always_ff @(posedge hclk or posedge hresetn) begin
    if (hresetn) begin
      state_q     <= ST_IDLE_OK;
      dph_valid_q <= 1'b0;
      dph_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dph_valid_q <= dph_valid_d;
      dph_write_q <= dph_write_d;
    end
  end

  always_ff @(posedge hclk) begin
    dph_addr_q <= dph_addr_d;
    dph_size_q <= dph_size_d;
  end

  // Data phase: a write commits at the end of its (single) data-phase cycle,
  // so a read in the following data phase already sees it.
  always_comb begin
    mem_we = (state_q == ST_IDLE_OK) && dph_valid_q && dph_write_q;
    mem_be = lane_en(dph_addr_q[LANE_W-1:0], dph_size_q);
  end

  ahb_modport_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (hclk),
    .rst   (hresetn),
    .we    (mem_we),
    .be    (mem_be),
    .idx   (dph_addr_q[DPH_AW-1:LANE_W]),
    .wdata (bus.hwdata),
    .rdata (mem_rdata)
  );

  // Outputs are decoded from registered state so reset clears them at once.
  always_comb begin
    bus.hready = hready_int;
    bus.hresp  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? ERROR : OKAY;
    bus.hrdata = ((state_q == ST_IDLE_OK) && dph_valid_q && !dph_write_q)
                 ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_ahb_modport.sv
// tb_ahb_modport
// Directed bench for ahb_modport: acts as the AHB master through
// ahb_modport_if and checks hready/hresp/hrdata against hand-computed values.
module tb_ahb_modport;

  logic hclk = 1'b0;
  logic hresetn;
  int   n_cmp = 0;
  int   n_err = 0;

  ahb_modport_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb_modport #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (64)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_addr(input logic [1:0] trans, input logic wr,
                          input logic [2:0] size, input logic [31:0] addr);
    bus.htrans = trans;
    bus.hburst = 3'b001;
    bus.hwrite = wr;
    bus.hsize  = size;
    bus.haddr  = addr;
  endtask

  task automatic chk_resp(input string tag, input logic rdy, input logic [1:0] resp);
    chk({tag, "_hready"}, 32'(bus.hready), 32'(rdy));
    chk({tag, "_hresp"},  32'(bus.hresp),  32'(resp));
  endtask

  // Address phase in the current cycle, then the write data phase. Returns
  // inside the data phase so the caller can overlap the next address phase.
  task automatic do_write(input string tag, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] data);
    set_addr(2'b10, 1'b1, size, addr);
    step();
    bus.hwdata = data;
    bus.htrans = 2'b00;
    chk_resp(tag, 1'b1, 2'b00);
    chk({tag, "_hrdata"}, bus.hrdata, 32'h0);
  endtask

  task automatic do_read(input string tag, input logic [1:0] trans,
                         input logic [31:0] addr, input logic [31:0] exp);
    set_addr(trans, 1'b0, 3'd2, addr);
    step();
    bus.htrans = 2'b00;
`ifdef AHB_WAIT_STATE_EN
    chk_resp({tag, "_wait"}, 1'b0, 2'b00);
    chk({tag, "_wait_hrdata"}, bus.hrdata, 32'h0);
    step();
`endif
    chk_resp(tag, 1'b1, 2'b00);
    chk({tag, "_hrdata"}, bus.hrdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_addr(2'b00, 1'b0, 3'd2, 32'h0);
    bus.hwdata = 32'h0;
    hresetn = 1'b0;
    #2 hresetn = 1'b1;
    #1;
    chk_resp("reset", 1'b1, 2'b00);
    chk("reset_hrdata", bus.hrdata, 32'h0);
    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b0;

    // Freshly cleared memory reads zero.
    do_read("rd10_rst", 2'b10, 32'h10, 32'h0);

    // Word write immediately followed by a read of the same address.
    do_write("wr10", 32'h10, 3'd2, 32'hDEADBEEF);
    do_read("rd10_b2b", 2'b10, 32'h10, 32'hDEADBEEF);

    // Byte write to lane 3, halfword write to lanes 3:2 of the next word.
    do_write("wrb13", 32'h13, 3'd0, 32'hAA000000);
    do_read("rd10_byte", 2'b10, 32'h10, 32'hAAADBEEF);
    do_write("wrh16", 32'h16, 3'd1, 32'hCAFE0000);
    do_read("rd14_seq", 2'b11, 32'h14, 32'hCAFE0000);

    // Idle cycle after a read: hrdata returns to zero.
    step();
    chk_resp("idle", 1'b1, 2'b00);
    chk("idle_hrdata", bus.hrdata, 32'h0);

    // Misaligned word read; a write presented during ERR1 must be ignored.
    set_addr(2'b10, 1'b0, 3'd2, 32'h02);
    step();
    set_addr(2'b10, 1'b1, 3'd2, 32'h00);
    bus.hwdata = 32'h11111111;
    chk_resp("unal_err1", 1'b0, 2'b01);
    chk("unal_err1_hrdata", bus.hrdata, 32'h0);
    step();
    bus.htrans = 2'b00;
    chk_resp("unal_err2", 1'b1, 2'b01);
    step();
    chk_resp("unal_after", 1'b1, 2'b00);
    do_read("rd00_ignored", 2'b10, 32'h00, 32'h0);
    do_read("rd10_unchanged", 2'b10, 32'h10, 32'hAAADBEEF);

    // Out-of-range write, then an oversized transfer chained from ERR2.
    set_addr(2'b10, 1'b1, 3'd2, 32'h100);
    step();
    bus.htrans = 2'b00;
    bus.hwdata = 32'h55555555;
    chk_resp("range_err1", 1'b0, 2'b01);
    step();
    chk_resp("range_err2", 1'b1, 2'b01);
    set_addr(2'b10, 1'b0, 3'd3, 32'h00);
    step();
    bus.htrans = 2'b00;
    chk_resp("size_err1", 1'b0, 2'b01);
    step();
    chk_resp("size_err2", 1'b1, 2'b01);
    do_read("rd00_after_err", 2'b10, 32'h00, 32'h0);
    do_read("rd_fc_last", 2'b10, 32'hFC, 32'h0);

    // BUSY and IDLE with write control must not touch memory.
    set_addr(2'b01, 1'b1, 3'd2, 32'h10);
    step();
    bus.hwdata = 32'hFFFFFFFF;
    chk_resp("busy", 1'b1, 2'b00);
    chk("busy_hrdata", bus.hrdata, 32'h0);
    set_addr(2'b00, 1'b1, 3'd2, 32'h10);
    step();
    chk_resp("idle_wr", 1'b1, 2'b00);
    bus.htrans = 2'b00;
    do_read("rd10_no_access", 2'b10, 32'h10, 32'hAAADBEEF);

    // Reset during a read data phase clears hrdata immediately.
    hresetn = 1'b1;
    #1;
    chk("rst_rd_hrdata", bus.hrdata, 32'h0);
    chk_resp("rst_rd", 1'b1, 2'b00);
    @(posedge hclk);
    #1 hresetn = 1'b0;

    // Reset during ERR1 returns to OKAY immediately.
    set_addr(2'b10, 1'b0, 3'd2, 32'h02);
    step();
    bus.htrans = 2'b00;
    chk_resp("pre_rst_err1", 1'b0, 2'b01);
    hresetn = 1'b1;
    #1;
    chk_resp("rst_err1", 1'b1, 2'b00);
    @(posedge hclk);
    #1 hresetn = 1'b0;
    do_read("rd10_cleared", 2'b10, 32'h10, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_modport.md
# ahb_modport

AHB slave endpoint sitting on the slave side of the AHB bus (it drives hready/hresp/hrdata and samples htrans/hburst/hsize/hwrite/haddr/hwdata). It implements an AHB-Lite-style word-addressed memory with byte-lane writes, zero-wait-state OKAY responses and a two-cycle ERROR response. It is the responder that the master agent and bus monitors are exercised against.

## Interface
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width (32 or 64).
- MEM_DEPTH, 64, memory size in DATA_WIDTH words; valid byte range is 0 to MEM_DEPTH*DATA_WIDTH/8-1.
- hclk  input  1  bus clock; all state changes on rising edge.
- hresetn  input  1  reset; one clock; reset is asynchronous and active-high (asserted when 1, port keeps the codebase name).
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hburst  input  3  burst type; sampled, informational only (no effect on response).
- hsize  input  3  transfer size, bytes = 2**hsize.
- hwrite  input  1  1 = write, 0 = read.
- haddr  input  ADDR_WIDTH  byte address.
- hwdata  input  DATA_WIDTH  write data, valid in data phase.
- hrdata  output  DATA_WIDTH  read data, valid in data phase when hready=1.
- hready  output  1  1 = current data phase completes this cycle.
- hresp  output  2  OKAY=00, ERROR=01; RETRY/SPLIT never driven.

## Operation
- Address phase accepted on rising edge when hready=1 and htrans is NONSEQ or SEQ; registers haddr, hsize, hwrite. IDLE/BUSY accepted -> OKAY, no access.
- Error check at acceptance: hsize > log2(DATA_WIDTH/8), address not aligned to 2**hsize, or address beyond memory -> transfer flagged error.
- Write (no error): in data phase, hwdata byte lanes selected by registered hsize and haddr low bits are written to word haddr/(DATA_WIDTH/8) at the end of that cycle; other bytes unchanged.
- Read (no error): hrdata = full stored word at registered address (all lanes, little-endian lane mapping); master extracts lanes.
- Back-to-back write then read of the same address: read returns the newly written data (write commits before next data phase).
- Error response: cycle 1 hready=0 hresp=01; cycle 2 hready=1 hresp=01. No memory write. Address phase presented during cycle 1 is ignored (hready=0); the master re-presents it.
- States: IDLE_OK, ERR1, ERR2 (plus WAIT when configured). IDLE_OK->ERR1 on flagged transfer; ERR1->ERR2; ERR2->IDLE_OK or ERR1 if new accepted transfer is erroneous.

## Timing
- Reset values: hready=1, hresp=00, hrdata=0, all memory words 0, state IDLE_OK.
- Reset mid-transfer: outputs return to reset values immediately; pending write discarded.
- OKAY transfers: zero wait states; one transfer per cycle in pipeline (address N+1 overlaps data N).
- hrdata holds 0 outside read data phases.

## Configuration
- AHB_WAIT_STATE_EN defined: every non-error read inserts exactly one wait state (hready=0, hresp=00 one cycle, then hready=1 with data). Writes unchanged.
- Not defined: all OKAY transfers zero-wait.

## Structure
- Package ahb_modport_pkg: htrans_t, hsize_t, hburst_t, hresp_t enums and OKAY/ERROR constants.
- Sub-module ahb_modport_mem: MEM_DEPTH x DATA_WIDTH flop array with per-byte write enables, async clear, combinational read.

## Test plan
- Reset asserted: hready=1, hresp=00, hrdata=0; read addr 0x10 after release -> 0x00000000.
- NONSEQ word write 0x10=0xDEADBEEF then NONSEQ read 0x10 -> hrdata 0xDEADBEEF, hresp=00, no wait states.
- Byte write hsize=0 addr 0x13 data 0xAA000000 onto 0xDEADBEEF, read 0x10 -> 0xAAADBEEF.
- Unaligned word read addr 0x02 -> cycle 1 hready=0 hresp=01, cycle 2 hready=1 hresp=01; memory unchanged.
- Write to addr 0x100 (beyond 64 words) -> two-cycle ERROR, then read 0x00 -> 0, OKAY.
- With AHB_WAIT_STATE_EN: read 0x10 -> one cycle hready=0 hresp=00, then data; IDLE/BUSY transfers -> OKAY, no access.
